mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one memory bus port between the IF-stage instruction fetch and the MEM-stage load/store driven from the EX/MEM register outputs.
- Sequences one transaction at a time: arbitrate, issue with a request/ready handshake, wait for the response, then route the response back to the owner.
- Produces stall_if and stall_mem so the pipeline holds while its access is pending.

Parameters:
- STARVE_LIMIT, 4: consecutive fetch losses before fetch is forced to win; 0 means pure data priority.
- TIMEOUT_CYCLES, 255: cycles allowed in REQ+WAIT before abort; used only with MEM_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- if_req_valid  in  1  fetch request; held until if_rvalid
- if_addr  in  32  fetch address
- flush_if  in  1  discard any in-flight fetch response
- if_rvalid  out  1  fetch completion pulse
- if_rdata  out  32  fetch data; 0 when if_rvalid=0
- dm_req_valid  in  1  load/store request; held until dm_rvalid
- dm_addr  in  32  data address
- dm_we  in  1  1 = store
- dm_wdata  in  32  store data
- dm_wstrb  in  4  byte strobes
- dm_rvalid  out  1  data completion pulse; also the ack for stores
- dm_rdata  out  32  load data; 0 when dm_rvalid=0
- bus_req_valid  out  1  bus request
- bus_addr  out  32  latched address
- bus_we  out  1  latched write enable
- bus_wdata  out  32  latched write data
- bus_wstrb  out  4  latched strobes
- bus_req_ready  in  1  bus accepts request
- bus_rsp_valid  in  1  bus response
- bus_rdata  in  32  bus read data
- stall_if  out  1  if_req_valid & ~if_rvalid
- stall_mem  out  1  dm_req_valid & ~dm_rvalid

Behaviour:
- Reset: asynchronous, active-low on reset_n; clock clk. State=IDLE. All registered outputs and bus_* outputs are 0. Starvation counter=0, owner=0, drop flag=0.
- States:
  - IDLE: if any request is valid, choose a winner, latch its addr/we/wdata/wstrb into the bus_* registers, record the owner, go to REQ.
    - A fetch latches we=0 and wstrb=0.
  - REQ: bus_req_valid=1 and bus_* held stable; on bus_req_ready go to WAIT.
  - WAIT: on bus_rsp_valid, go to IDLE.
    - In that cycle, owner's rvalid=1 (combinational) and its rdata=bus_rdata.
- Arbitration (IDLE only):
  - Data wins over fetch by default, since the MEM-stage access is older.
  - Starvation counter (4-bit, saturating) increments when both are valid and data wins. It clears when fetch is granted.
  - When STARVE_LIMIT≠0 and counter==STARVE_LIMIT with both valid, fetch wins.
- Latency with a zero-wait bus: request seen in cycle N, bus_req_valid in N+1, rvalid in N+2, next arbitration in N+3.
- Requester rule: in the cycle after rvalid, a requester either drops valid or presents a new request. That cycle is IDLE, so no stale re-grant occurs.
- bus_rsp_valid in IDLE or REQ is ignored.
- Flush:
  - flush_if high while the owner is fetch and state is REQ/WAIT sets the drop flag.
  - flush_if in the response cycle also drops.
  - A dropped response still completes the bus transaction, but if_rvalid stays 0. The drop flag clears on return to IDLE.
  - flush_if never affects a data transaction.
- Reset mid-transaction: returns to IDLE at once and bus_req_valid drops. Any later bus response is ignored.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- With the macro:
  - Adds outputs if_err and dm_err (1 bit, reset 0) and an 8-bit timeout counter.
  - The counter clears on leaving IDLE and increments each REQ/WAIT cycle.
  - On reaching TIMEOUT_CYCLES, the block:
    - drops bus_req_valid;
    - pulses the owner's rvalid with err=1 and rdata=0;
    - returns to IDLE.
  - A flushed fetch that times out gives no if_rvalid.
- Without the macro: no err ports or counter; the block waits indefinitely.

Test Plan:
- Fetch only, zero-wait bus: if_addr=0x100 at cycle 0, bus_rdata=0xDEADBEEF -> bus_addr=0x100 in cycle 1; if_rvalid=1 with if_rdata=0xDEADBEEF in cycle 2; stall_if high in cycles 0-1.
- Simultaneous requests: fetch 0x200 and store 0x8000/0x12345678/wstrb=0xF -> data first (bus_we=1, bus_wdata=0x12345678), dm_rvalid; then fetch 0x200 issued.
- Starvation, STARVE_LIMIT=2: continuous data and fetch requests -> grant order D,D,F,D,D,F.
- Backpressure: bus_req_ready low for 5 cycles -> bus_addr/bus_wdata stable; stall_mem high throughout. Reset asserted mid-WAIT -> all outputs 0; a late response is ignored.
- Flush: flush_if pulsed during fetch WAIT -> no if_rvalid; the next fetch completes normally.
- Timeout with MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, no bus response -> dm_rvalid=1, dm_err=1, dm_rdata=0 on the 8th REQ/WAIT cycle; state returns to IDLE.

Source files
------------

// File: rtl/mem_port_if.sv
// Bundles the fetch, data and memory-bus handshakes shared by mem_port_arbiter.
// The error outputs exist only when MEM_ARB_TIMEOUT_EN is defined.
interface mem_port_if;
  logic        if_req_valid;
  logic [31:0] if_addr;
  logic        flush_if;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req_valid;
  logic [31:0] dm_addr;
  logic        dm_we;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_wstrb;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        bus_req_valid;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_req_ready;
  logic        bus_rsp_valid;
  logic [31:0] bus_rdata;
  logic        stall_if;
  logic        stall_mem;
`ifdef MEM_ARB_TIMEOUT_EN
  logic        if_err;
  logic        dm_err;
`endif

  // Environment side: pipeline requesters and the memory bus.
  modport master (
`ifdef MEM_ARB_TIMEOUT_EN
    input  if_err, dm_err,
`endif
    output if_req_valid, if_addr, flush_if, dm_req_valid, dm_addr, dm_we, dm_wdata, dm_wstrb,
    output bus_req_ready, bus_rsp_valid, bus_rdata,
    input  if_rvalid, if_rdata, dm_rvalid, dm_rdata, stall_if, stall_mem,
    input  bus_req_valid, bus_addr, bus_we, bus_wdata, bus_wstrb
  );

  // Arbiter side.
  modport slave (
`ifdef MEM_ARB_TIMEOUT_EN
    output if_err, dm_err,
`endif
    input  if_req_valid, if_addr, flush_if, dm_req_valid, dm_addr, dm_we, dm_wdata, dm_wstrb,
    input  bus_req_ready, bus_rsp_valid, bus_rdata,
    output if_rvalid, if_rdata, dm_rvalid, dm_rdata, stall_if, stall_mem,
    output bus_req_valid, bus_addr, bus_we, bus_wdata, bus_wstrb
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus port between instruction fetch and MEM-stage load/store,
// one transaction at a time. Define MEM_ARB_TIMEOUT_EN to add the REQ/WAIT timeout.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic      clk,
  input  logic      reset_n,
  mem_port_if.slave mem_if
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        drop_q, drop_d;
  logic [3:0]  starve_q, starve_d;
  logic        bus_req_valid_q, bus_req_valid_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_wstrb_q, bus_wstrb_d;

  logic starve_hit_s;
  logic grant_if_s;
  logic rsp_done_s;
  logic tmo_fire_s;
  logic if_done_s;
  logic dm_done_s;

  assign starve_hit_s = (STARVE_LIMIT != 0) && (int'(starve_q) == STARVE_LIMIT);
  assign grant_if_s   = mem_if.if_req_valid && (!mem_if.dm_req_valid || starve_hit_s);
  assign rsp_done_s   = (state_q == WAIT) && mem_if.bus_rsp_valid;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [7:0] tmo_q, tmo_d;

  // A real response in the same cycle as expiry wins over the timeout.
  assign tmo_fire_s = (state_q != IDLE) && (tmo_q == 8'(TIMEOUT_CYCLES - 1)) && !rsp_done_s;
  assign tmo_d      = (state_q == IDLE) ? 8'd0 : tmo_q + 8'd1;

  // Timeout counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_q <= 8'd0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_fire_s = 1'b0;
`endif

  // FSM state and latched bus request registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      owner_q         <= OWN_IF;
      drop_q          <= 1'b0;
      starve_q        <= 4'd0;
      bus_req_valid_q <= 1'b0;
      bus_addr_q      <= 32'd0;
      bus_we_q        <= 1'b0;
      bus_wdata_q     <= 32'd0;
      bus_wstrb_q     <= 4'd0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      drop_q          <= drop_d;
      starve_q        <= starve_d;
      bus_req_valid_q <= bus_req_valid_d;
      bus_addr_q      <= bus_addr_d;
      bus_we_q        <= bus_we_d;
      bus_wdata_q     <= bus_wdata_d;
      bus_wstrb_q     <= bus_wstrb_d;
    end
  end

  // Next-state: arbitration in IDLE, handshake in REQ, response/flush tracking in WAIT.
  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    drop_d          = drop_q;
    starve_d        = starve_q;
    bus_req_valid_d = bus_req_valid_q;
    bus_addr_d      = bus_addr_q;
    bus_we_d        = bus_we_q;
    bus_wdata_d     = bus_wdata_q;
    bus_wstrb_d     = bus_wstrb_q;

    case (state_q)
      IDLE: begin
        drop_d = 1'b0;
        if (mem_if.if_req_valid || mem_if.dm_req_valid) begin
          state_d         = REQ;
          bus_req_valid_d = 1'b1;
          if (grant_if_s) begin
            owner_d     = OWN_IF;
            bus_addr_d  = mem_if.if_addr;
            bus_we_d    = 1'b0;
            bus_wdata_d = 32'd0;
            bus_wstrb_d = 4'd0;
            starve_d    = 4'd0;
          end else begin
            owner_d     = OWN_DM;
            bus_addr_d  = mem_if.dm_addr;
            bus_we_d    = mem_if.dm_we;
            bus_wdata_d = mem_if.dm_wdata;
            bus_wstrb_d = mem_if.dm_wstrb;
            // Only a lost fetch counts as starvation; saturate at 15.
            if (mem_if.if_req_valid && (starve_q != 4'hF)) begin
              starve_d = starve_q + 4'd1;
            end else begin
              starve_d = starve_q;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        drop_d = drop_q || ((owner_q == OWN_IF) && mem_if.flush_if);
        if (tmo_fire_s) begin
          state_d         = IDLE;
          bus_req_valid_d = 1'b0;
          drop_d          = 1'b0;
        end else if (mem_if.bus_req_ready) begin
          state_d         = WAIT;
          bus_req_valid_d = 1'b0;
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        if (rsp_done_s || tmo_fire_s) begin
          state_d = IDLE;
          drop_d  = 1'b0;
        end else begin
          state_d = WAIT;
          drop_d  = drop_q || ((owner_q == OWN_IF) && mem_if.flush_if);
        end
      end
      default: begin
        state_d         = IDLE;
        bus_req_valid_d = 1'b0;
        drop_d          = 1'b0;
      end
    endcase
  end

  // A flush in the completing cycle itself also suppresses the fetch response.
  assign if_done_s = (rsp_done_s || tmo_fire_s) && (owner_q == OWN_IF) &&
                     !(drop_q || mem_if.flush_if);
  assign dm_done_s = (rsp_done_s || tmo_fire_s) && (owner_q == OWN_DM);

  assign mem_if.if_rvalid     = if_done_s;
  assign mem_if.if_rdata      = (if_done_s && rsp_done_s) ? mem_if.bus_rdata : 32'd0;
  assign mem_if.dm_rvalid     = dm_done_s;
  assign mem_if.dm_rdata      = (dm_done_s && rsp_done_s) ? mem_if.bus_rdata : 32'd0;
  assign mem_if.stall_if      = mem_if.if_req_valid && !if_done_s;
  assign mem_if.stall_mem     = mem_if.dm_req_valid && !dm_done_s;
  assign mem_if.bus_req_valid = bus_req_valid_q && !tmo_fire_s;
  assign mem_if.bus_addr      = bus_addr_q;
  assign mem_if.bus_we        = bus_we_q;
  assign mem_if.bus_wdata     = bus_wdata_q;
  assign mem_if.bus_wstrb     = bus_wstrb_q;
`ifdef MEM_ARB_TIMEOUT_EN
  assign mem_if.if_err        = if_done_s && tmo_fire_s;
  assign mem_if.dm_err        = dm_done_s && tmo_fire_s;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (STARVE_LIMIT=2; TIMEOUT_CYCLES=8
// when MEM_ARB_TIMEOUT_EN is defined).
module tb_mem_port_arbiter;
  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_pass;

  mem_port_if bus_if();

`ifdef MEM_ARB_TIMEOUT_EN
  mem_port_arbiter #(.STARVE_LIMIT(2), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n), .mem_if(bus_if));
`else
  mem_port_arbiter #(.STARVE_LIMIT(2)) dut (
    .clk(clk), .reset_n(reset_n), .mem_if(bus_if));
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; checks follow 2 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    bus_if.if_req_valid  = 1'b0;
    bus_if.if_addr       = 32'd0;
    bus_if.flush_if      = 1'b0;
    bus_if.dm_req_valid  = 1'b0;
    bus_if.dm_addr       = 32'd0;
    bus_if.dm_we         = 1'b0;
    bus_if.dm_wdata      = 32'd0;
    bus_if.dm_wstrb      = 4'd0;
    bus_if.bus_req_ready = 1'b0;
    bus_if.bus_rsp_valid = 1'b0;
    bus_if.bus_rdata     = 32'd0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_inputs();
    tick();
    settle();
    n_checks++; if ({bus_if.bus_req_valid, bus_if.bus_we, bus_if.if_rvalid, bus_if.dm_rvalid} !== 4'b0000) $display("FAIL reset_ctrl: got %b want 0000", {bus_if.bus_req_valid, bus_if.bus_we, bus_if.if_rvalid, bus_if.dm_rvalid}); else n_pass++;
    n_checks++; if ({bus_if.bus_addr, bus_if.bus_wdata, bus_if.bus_wstrb} !== 68'd0) $display("FAIL reset_bus: got %h want 0", {bus_if.bus_addr, bus_if.bus_wdata, bus_if.bus_wstrb}); else n_pass++;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    bus_if.if_req_valid  = 1'b1;
    bus_if.if_addr       = 32'h0000_0100;
    bus_if.bus_req_ready = 1'b1;
    bus_if.bus_rsp_valid = 1'b1;
    bus_if.bus_rdata     = 32'hDEAD_BEEF;
    settle();
    n_checks++; if ({bus_if.stall_if, bus_if.bus_req_valid} !== 2'b10) $display("FAIL fetch_c0: got %b want 10", {bus_if.stall_if, bus_if.bus_req_valid}); else n_pass++;
    tick(); settle();
    n_checks++; if (bus_if.bus_addr !== 32'h0000_0100) $display("FAIL fetch_addr: got %h want 00000100", bus_if.bus_addr); else n_pass++;
    n_checks++; if ({bus_if.bus_req_valid, bus_if.stall_if, bus_if.if_rvalid} !== 3'b110) $display("FAIL fetch_c1: got %b want 110", {bus_if.bus_req_valid, bus_if.stall_if, bus_if.if_rvalid}); else n_pass++;
    tick(); settle();
    n_checks++; if ({bus_if.if_rvalid, bus_if.stall_if} !== 2'b10) $display("FAIL fetch_c2: got %b want 10", {bus_if.if_rvalid, bus_if.stall_if}); else n_pass++;
    n_checks++; if (bus_if.if_rdata !== 32'hDEAD_BEEF) $display("FAIL fetch_rdata: got %h want deadbeef", bus_if.if_rdata); else n_pass++;
    tick();
    bus_if.if_req_valid = 1'b0;
    settle();
    n_checks++; if ({bus_if.if_rvalid, bus_if.if_rdata} !== 33'd0) $display("FAIL fetch_idle: got %h want 0", {bus_if.if_rvalid, bus_if.if_rdata}); else n_pass++;
    clear_inputs();
    tick();
  endtask

  task automatic test_simultaneous();
    bus_if.if_req_valid  = 1'b1;
    bus_if.if_addr       = 32'h0000_0200;
    bus_if.dm_req_valid  = 1'b1;
    bus_if.dm_addr       = 32'h0000_8000;
    bus_if.dm_we         = 1'b1;
    bus_if.dm_wdata      = 32'h1234_5678;
    bus_if.dm_wstrb      = 4'hF;
    bus_if.bus_req_ready = 1'b1;
    bus_if.bus_rsp_valid = 1'b1;
    bus_if.bus_rdata     = 32'hCAFE_0001;
    tick(); settle();
    n_checks++; if ({bus_if.bus_addr, bus_if.bus_we, bus_if.bus_wdata, bus_if.bus_wstrb} !== {32'h0000_8000, 1'b1, 32'h1234_5678, 4'hF}) $display("FAIL simul_data_req: got %h/%b/%h/%h want 00008000/1/12345678/f", bus_if.bus_addr, bus_if.bus_we, bus_if.bus_wdata, bus_if.bus_wstrb); else n_pass++;
    tick(); settle();
    n_checks++; if ({bus_if.dm_rvalid, bus_if.if_rvalid, bus_if.stall_if, bus_if.stall_mem} !== 4'b1010) $display("FAIL simul_data_done: got %b want 1010", {bus_if.dm_rvalid, bus_if.if_rvalid, bus_if.stall_if, bus_if.stall_mem}); else n_pass++;
    tick();
    bus_if.dm_req_valid = 1'b0;
    tick(); settle();
    n_checks++; if ({bus_if.bus_addr, bus_if.bus_we, bus_if.bus_wstrb} !== {32'h0000_0200, 1'b0, 4'h0}) $display("FAIL simul_fetch_req: got %h/%b/%h want 00000200/0/0", bus_if.bus_addr, bus_if.bus_we, bus_if.bus_wstrb); else n_pass++;
    tick(); settle();
    n_checks++; if ({bus_if.if_rvalid, bus_if.if_rdata} !== {1'b1, 32'hCAFE_0001}) $display("FAIL simul_fetch_done: got %b/%h want 1/cafe0001", bus_if.if_rvalid, bus_if.if_rdata); else n_pass++;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_starvation();
    logic [5:0] fetch_turn;
    logic       f;
    fetch_turn = 6'b100100;
    bus_if.if_req_valid  = 1'b1;
    bus_if.if_addr       = 32'h0000_0500;
    bus_if.dm_req_valid  = 1'b1;
    bus_if.dm_addr       = 32'h0000_9000;
    bus_if.bus_req_ready = 1'b1;
    bus_if.bus_rsp_valid = 1'b1;
    for (int g = 0; g < 6; g++) begin
      f = fetch_turn[g];
      tick(); settle();
      n_checks++; if (bus_if.bus_addr !== (f ? 32'h0000_0500 : 32'h0000_9000)) $display("FAIL starve_grant%0d: got %h want %h", g, bus_if.bus_addr, (f ? 32'h0000_0500 : 32'h0000_9000)); else n_pass++;
      tick(); settle();
      n_checks++; if ({bus_if.if_rvalid, bus_if.dm_rvalid} !== (f ? 2'b10 : 2'b01)) $display("FAIL starve_done%0d: got %b want %b", g, {bus_if.if_rvalid, bus_if.dm_rvalid}, (f ? 2'b10 : 2'b01)); else n_pass++;
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_backpressure_reset();
    bus_if.dm_req_valid = 1'b1;
    bus_if.dm_addr      = 32'h0000_8800;
    bus_if.dm_we        = 1'b1;
    bus_if.dm_wdata     = 32'hA5A5_A5A5;
    bus_if.dm_wstrb     = 4'h3;
    for (int c = 1; c <= 5; c++) begin
      tick(); settle();
      n_checks++; if ({bus_if.bus_req_valid, bus_if.stall_mem, bus_if.bus_addr, bus_if.bus_wdata} !== {2'b11, 32'h0000_8800, 32'hA5A5_A5A5}) $display("FAIL bp_hold%0d: got %b/%b/%h/%h want 1/1/00008800/a5a5a5a5", c, bus_if.bus_req_valid, bus_if.stall_mem, bus_if.bus_addr, bus_if.bus_wdata); else n_pass++;
    end
    tick();
    bus_if.bus_req_ready = 1'b1;
    tick();
    bus_if.bus_req_ready = 1'b0;
    settle();
    n_checks++; if ({bus_if.bus_req_valid, bus_if.stall_mem, bus_if.dm_rvalid} !== 3'b010) $display("FAIL bp_wait: got %b want 010", {bus_if.bus_req_valid, bus_if.stall_mem, bus_if.dm_rvalid}); else n_pass++;
    reset_n = 1'b0;
    #1;
    n_checks++; if ({bus_if.bus_req_valid, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata, bus_if.bus_wstrb, bus_if.dm_rvalid} !== 71'd0) $display("FAIL bp_reset: got %h want 0", {bus_if.bus_req_valid, bus_if.bus_we, bus_if.bus_addr, bus_if.bus_wdata, bus_if.bus_wstrb, bus_if.dm_rvalid}); else n_pass++;
    bus_if.dm_req_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    bus_if.bus_rsp_valid = 1'b1;
    bus_if.bus_rdata     = 32'h7777_7777;
    settle();
    n_checks++; if ({bus_if.dm_rvalid, bus_if.dm_rdata} !== 33'd0) $display("FAIL late_rsp: got %h want 0", {bus_if.dm_rvalid, bus_if.dm_rdata}); else n_pass++;
    tick(); settle();
    n_checks++; if ({bus_if.dm_rvalid, bus_if.bus_req_valid} !== 2'b00) $display("FAIL late_rsp_idle: got %b want 00", {bus_if.dm_rvalid, bus_if.bus_req_valid}); else n_pass++;
    clear_inputs();
    tick();
  endtask

  task automatic test_flush();
    bus_if.if_req_valid  = 1'b1;
    bus_if.if_addr       = 32'h0000_0300;
    bus_if.bus_req_ready = 1'b1;
    tick(); tick();
    bus_if.flush_if = 1'b1;
    settle();
    n_checks++; if (bus_if.if_rvalid !== 1'b0) $display("FAIL flush_wait: got %b want 0", bus_if.if_rvalid); else n_pass++;
    tick();
    bus_if.flush_if      = 1'b0;
    bus_if.bus_rsp_valid = 1'b1;
    bus_if.bus_rdata     = 32'h1111_1111;
    settle();
    n_checks++; if ({bus_if.if_rvalid, bus_if.if_rdata, bus_if.stall_if} !== {1'b0, 32'd0, 1'b1}) $display("FAIL flush_drop: got %b/%h/%b want 0/0/1", bus_if.if_rvalid, bus_if.if_rdata, bus_if.stall_if); else n_pass++;
    tick();
    bus_if.if_addr   = 32'h0000_0400;
    bus_if.bus_rdata = 32'h2222_2222;
    tick(); settle();
    n_checks++; if (bus_if.bus_addr !== 32'h0000_0400) $display("FAIL flush_next_addr: got %h want 00000400", bus_if.bus_addr); else n_pass++;
    tick(); settle();
    n_checks++; if ({bus_if.if_rvalid, bus_if.if_rdata} !== {1'b1, 32'h2222_2222}) $display("FAIL flush_next_done: got %b/%h want 1/22222222", bus_if.if_rvalid, bus_if.if_rdata); else n_pass++;
    tick();
    bus_if.if_addr = 32'h0000_0600;
    tick(); tick();
    bus_if.flush_if = 1'b1;
    settle();
    n_checks++; if (bus_if.if_rvalid !== 1'b0) $display("FAIL flush_rsp_cycle: got %b want 0", bus_if.if_rvalid); else n_pass++;
    tick();
    bus_if.if_req_valid = 1'b0;
    bus_if.dm_req_valid = 1'b1;
    bus_if.dm_addr      = 32'h0000_9400;
    bus_if.bus_rdata    = 32'h3333_4444;
    tick(); tick(); settle();
    n_checks++; if ({bus_if.dm_rvalid, bus_if.dm_rdata} !== {1'b1, 32'h3333_4444}) $display("FAIL flush_data_unaffected: got %b/%h want 1/33334444", bus_if.dm_rvalid, bus_if.dm_rdata); else n_pass++;
    tick();
    clear_inputs();
    tick();
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bus_if.dm_req_valid = 1'b1;
    bus_if.dm_addr      = 32'h0000_9100;
    bus_if.bus_rdata    = 32'h3333_3333;
    for (int k = 1; k <= 8; k++) begin
      tick(); settle();
      if (k < 8) begin
        n_checks++; if ({bus_if.dm_rvalid, bus_if.dm_err} !== 2'b00) $display("FAIL tmo_pending%0d: got %b want 00", k, {bus_if.dm_rvalid, bus_if.dm_err}); else n_pass++;
      end else begin
        n_checks++; if ({bus_if.dm_rvalid, bus_if.dm_err, bus_if.dm_rdata, bus_if.bus_req_valid} !== {2'b11, 32'd0, 1'b0}) $display("FAIL tmo_fire: got %b/%b/%h/%b want 1/1/0/0", bus_if.dm_rvalid, bus_if.dm_err, bus_if.dm_rdata, bus_if.bus_req_valid); else n_pass++;
      end
    end
    tick();
    bus_if.dm_req_valid = 1'b0;
    settle();
    n_checks++; if ({bus_if.bus_req_valid, bus_if.dm_err, bus_if.dm_rvalid} !== 3'b000) $display("FAIL tmo_idle: got %b want 000", {bus_if.bus_req_valid, bus_if.dm_err, bus_if.dm_rvalid}); else n_pass++;
    clear_inputs();
    tick();
  endtask
`endif

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_fetch();
    test_simultaneous();
    test_starvation();
    test_backpressure_reset();
    test_flush();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
